sd_crc16_lanes: RTL and testbench

Parametrised multi-lane CRC-16 generator/checker for the SD data path of the AXI-SD bridge. It runs one independent CRC-16 LFSR per SD DAT line: 1, 4 or 8 lanes, polynomial x^16+x^12+x^5+1, one bit per lane per clock. It serialises the finished CRCs MSB-first onto the lanes for transmit, and flags per-lane zero remainders for receive-side checking. It sits between the data shift registers and the DAT pad drivers/samplers, clocked on the SD bit clock enable domain.

---
 rtl/sd_crc16_lanes_if.sv | 42 ++++
 rtl/sd_crc16_lanes.sv | 104 ++++++++++
 tb/tb_sd_crc16_lanes.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_crc16_lanes_if.sv
// Handshake/bus bundle for the multi-lane SD CRC-16 block.
// The master drives data and control; the slave (CRC block) returns results.
interface sd_crc16_lanes_if #(
    parameter int LANES = 4
);
    logic                   clear;
    logic                   en;
    logic [LANES-1:0]       din;
    logic                   out_start;
    logic [16*LANES-1:0]    crc;
    logic [LANES-1:0]       crc_zero;
    logic                   busy;
    logic                   out_valid;
    logic [LANES-1:0]       out_bit;
    logic                   out_last;

    modport master (
        output clear,
        output en,
        output din,
        output out_start,
        input  crc,
        input  crc_zero,
        input  busy,
        input  out_valid,
        input  out_bit,
        input  out_last
    );

    modport slave (
        input  clear,
        input  en,
        input  din,
        input  out_start,
        output crc,
        output crc_zero,
        output busy,
        output out_valid,
        output out_bit,
        output out_last
    );
endinterface

// File: rtl/sd_crc16_lanes.sv
// One CRC-16 LFSR per SD DAT line, with MSB-first serial shift-out.
// Feeding data plus received CRC leaves a zero remainder on a good lane.
module sd_crc16_lanes #(
    parameter int          LANES = 4,
    parameter logic [15:0] POLY  = 16'h1021
) (
    input logic              clk,
    input logic              rst,
    sd_crc16_lanes_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [LANES-1:0][15:0] crc_q;

    logic [LANES-1:0][15:0] absorb_d;
    logic [LANES-1:0][15:0] shift_d;
    logic [LANES-1:0]       zero_d;
    logic [LANES-1:0]       bit_d;
    logic                   shifting;

    // One serial LFSR step: feedback is incoming bit xor current MSB.
    function automatic logic [15:0] lfsr_step(
        input logic [15:0] r,
        input logic        b
    );
        logic fb;
        fb = b ^ r[15];
        return {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    assign shifting = (state_q == SHIFT);

    // Candidate next remainders for absorbing data and for shifting out.
    always_comb begin
        absorb_d = '0;
        shift_d  = '0;
        for (int k = 0; k < LANES; k++) begin
            absorb_d[k] = lfsr_step(crc_q[k], bus.din[k]);
            shift_d[k]  = {crc_q[k][14:0], 1'b0};
        end
    end

    // Control FSM and remainder registers; clear beats start beats data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            crc_q   <= '0;
        end else if (bus.clear) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            crc_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.out_start) begin
                        state_q <= SHIFT;
                        cnt_q   <= 4'd15;
                    end else if (bus.en) begin
                        crc_q <= absorb_d;
                    end
                end
                SHIFT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        crc_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        crc_q <= shift_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                    crc_q   <= '0;
                end
            endcase
        end
    end

    // Per-lane outputs derived purely from registers.
    always_comb begin
        zero_d = '0;
        bit_d  = '0;
        for (int k = 0; k < LANES; k++) begin
            zero_d[k] = (crc_q[k] == 16'h0000);
            bit_d[k]  = shifting & crc_q[k][15];
        end
    end

    assign bus.crc       = crc_q;
    assign bus.crc_zero  = zero_d;
    assign bus.busy      = shifting;
    assign bus.out_valid = shifting;
    assign bus.out_bit   = bit_d;
    assign bus.out_last  = shifting && (cnt_q == 4'd0);

endmodule

// File: tb/tb_sd_crc16_lanes.sv
// Randomised and directed bench for sd_crc16_lanes against a polynomial model.
// Model tracks M(x)*x^16 mod G per lane and a 16-bit MSB-first output window.
module tb_sd_crc16_lanes;
    localparam int          LANES = 4;
    localparam int          W     = 16 * LANES;
    localparam logic [15:0] POLY  = 16'h1021;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_crc16_lanes_if #(.LANES(LANES)) bus ();

    sd_crc16_lanes #(.LANES(LANES), .POLY(POLY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] m_rem  [LANES];
    logic [15:0] m_hold [LANES];
    int          m_left;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Remainder of (M*x + b) * x^16 modulo G, given R = M*x^16 mod G.
    function automatic logic [15:0] mod_append(input logic [15:0] r, input logic b);
        logic [16:0] t;
        t = {r, 1'b0} ^ {b, 16'h0000};
        if (t[16]) t = t ^ {1'b1, POLY};
        return t[15:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            m_rem[k]  = 16'h0;
            m_hold[k] = 16'h0;
        end
        m_left = 0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.clear) begin
                model_reset();
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0)
                    for (int k = 0; k < LANES; k++) m_rem[k] = 16'h0;
            end else if (bus.out_start) begin
                for (int k = 0; k < LANES; k++) m_hold[k] = m_rem[k];
                m_left = 16;
            end else if (bus.en) begin
                for (int k = 0; k < LANES; k++)
                    m_rem[k] = mod_append(m_rem[k], bus.din[k]);
            end
        end
    end

    task automatic compare_all();
        logic [W-1:0]     e_crc;
        logic [LANES-1:0] e_zero;
        logic [LANES-1:0] e_bit;
        logic [15:0]      v;
        e_crc  = '0;
        e_zero = '0;
        e_bit  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (m_left > 0) begin
                v = m_hold[k] << (16 - m_left);
                e_bit[k] = m_hold[k][m_left-1];
            end else begin
                v = m_rem[k];
            end
            e_crc[16*k +: 16] = v;
            e_zero[k] = (v == 16'h0);
        end
        check("crc", bus.crc, e_crc);
        check("crc_zero", bus.crc_zero, e_zero);
        check("busy", bus.busy, m_left > 0);
        check("out_valid", bus.out_valid, m_left > 0);
        check("out_bit", bus.out_bit, e_bit);
        check("out_last", bus.out_last, m_left == 1);
    endtask

    always @(posedge clk) begin
        #2;
        compare_all();
    end

    task automatic cyc(input logic c, input logic e, input logic [LANES-1:0] d,
                       input logic s);
        bus.clear     = c;
        bus.en        = e;
        bus.din       = d;
        bus.out_start = s;
        @(negedge clk);
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_crc"}, bus.crc, '0);
        check({tag, "_zero"}, bus.crc_zero, 4'hF);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_valid"}, bus.out_valid, 1'b0);
        check({tag, "_bit"}, bus.out_bit, '0);
        check({tag, "_last"}, bus.out_last, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] stream;
        logic [15:0] crcval;
        int          nvalid;
        int          last_idx;
        int          r;

        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.en        = 1'b0;
        bus.din       = '0;
        bus.out_start = 1'b0;
        model_reset();
        #3;
        reset_literals("reset");
        @(negedge clk);
        rst = 1'b0;

        // single data bit on lane 0
        cyc(1'b0, 1'b1, 4'b0001, 1'b0);
        check("single_lane0", bus.crc[15:0], 16'h1021);
        check("single_others", bus.crc[63:16], '0);
        check("single_zero", bus.crc_zero, 4'b1110);

        // 512 bytes of 0xFF on lane 0
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4096; i++) cyc(1'b0, 1'b1, 4'b0001, 1'b0);
        check("blk_lane0", bus.crc[15:0], 16'h7FA1);
        check("blk_others", bus.crc[63:16], '0);

        // shift-out, with ignored start requests while busy and on the last bit
        cyc(1'b0, 1'b0, '0, 1'b1);
        stream   = '0;
        nvalid   = 0;
        last_idx = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.out_valid) begin
                stream = {stream[14:0], bus.out_bit[0]};
                nvalid++;
                if (bus.out_last) last_idx = nvalid;
            end
            bus.out_start = bus.out_valid;
            @(negedge clk);
        end
        check("shift_stream", stream, 16'h7FA1);
        check("shift_nvalid", nvalid, 16);
        check("shift_last_idx", last_idx, 16);
        check("shift_done_busy", bus.busy, 1'b0);
        check("shift_done_crc", bus.crc, '0);

        // check path: good CRC then corrupted CRC
        for (int pass = 0; pass < 2; pass++) begin
            crcval = (pass == 0) ? 16'h7FA1 : 16'h7FA1 ^ 16'h0100;
            cyc(1'b1, 1'b0, '0, 1'b0);
            for (int i = 0; i < 4096; i++) cyc(1'b0, 1'b1, 4'b0001, 1'b0);
            for (int i = 0; i < 16; i++)
                cyc(1'b0, 1'b1, {3'b000, crcval[15-i]}, 1'b0);
            if (pass == 0) check("chk_good_zero", bus.crc_zero, 4'hF);
            else           check("chk_flip_zero0", bus.crc_zero[0], 1'b0);
        end

        // start and data together: start wins, bit dropped
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 4'hF, 1'b1);
        check("prio_busy", bus.busy, 1'b1);
        check("prio_crc", bus.crc, '0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0, 1'b0);
        check("prio_idle", bus.busy, 1'b0);

        // clear on the 8th shift-out cycle
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 4'($urandom), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, '0, 1'b0);
        check("abort_pre_busy", bus.busy, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_valid", bus.out_valid, 1'b0);
        check("abort_crc", bus.crc, '0);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            cyc(r < 2, $urandom_range(0, 3) != 0, 4'($urandom),
                (r >= 2) && (r < 7));
        end

        // async reset mid-absorb
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 4'($urandom), 1'b0);
        bus.en  = 1'b1;
        bus.din = 4'hF;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        reset_literals("arst_absorb");
        @(negedge clk);
        rst = 1'b0;

        // async reset mid-shift
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 4'($urandom), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        reset_literals("arst_shift");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
